// File: rtl/continuous_monitoring_system_pkg.sv
// Shared definitions for the continuous monitoring system trace path.
//   TRACE_BEAT_WIDTH   : width of one beat on the DMA/FIFO side
//   AXI_DATA_WIDTH     : width of one trace packet from the monitor
//   serializer_state_t : serializer FSM states
//   ceil_div()         : integer ceiling division for deriving beat counts
`timescale 1ns/1ps
package continuous_monitoring_system_pkg;

  localparam int TRACE_BEAT_WIDTH = 64;
  localparam int AXI_DATA_WIDTH   = 160;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } serializer_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/trace_axis_serializer_tlast_gen.sv
// trace_tlast_generator: decides whether the packet currently being emitted
// ends a transfer.
//   clk, rst        : clock, synchronous active-high reset
//   packet_done     : final beat of a packet handshaken this cycle
//   captured_tlast  : tlast flag captured with the packet in flight
//   capture         : a new packet is captured this cycle
//   tlast_interval  : packets per transfer (0 = input tlast only)
//   tlast_now       : current packet ends a transfer
`timescale 1ns/1ps
module trace_tlast_generator (
  input  logic        clk,
  input  logic        rst,
  input  logic        packet_done,
  input  logic        captured_tlast,
  input  logic        capture,
  input  logic [31:0] tlast_interval,
  output logic        tlast_now
);

  logic [31:0] interval_q, interval_d;
  logic [31:0] count_q, count_d;
  logic        interval_hit;

  always_comb begin
    interval_hit = (interval_q != 32'd0) && (count_q == interval_q - 32'd1);
    tlast_now    = captured_tlast | interval_hit;

    interval_d = capture ? tlast_interval : interval_q;

    // Any emitted tlast restarts the interval, whichever condition caused it.
    count_d = count_q;
    if (packet_done) begin
      count_d = tlast_now ? 32'd0 : count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      interval_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      interval_q <= interval_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/trace_axis_serializer.sv
// trace_axis_serializer: splits one wide trace packet into OUT_WIDTH-bit
// beats, least-significant beat first, and regenerates tlast per packet.
//   clk, rst            : clock, synchronous active-high reset
//   S_AXIS_*            : wide trace packet input (one packet per handshake)
//   M_AXIS_*            : beat output towards the DMA/FIFO
//   tlast_interval      : packets per transfer (0 = input tlast only)
//   beat_index          : index of the beat currently presented
//   packets_sent        : count of fully emitted packets (wraps)
`timescale 1ns/1ps
module trace_axis_serializer
  import continuous_monitoring_system_pkg::*;
#(
  parameter  int IN_WIDTH  = AXI_DATA_WIDTH,
  parameter  int OUT_WIDTH = TRACE_BEAT_WIDTH,
  localparam int NUM_BEATS = ceil_div(IN_WIDTH, OUT_WIDTH),
  localparam int IDX_W     = $clog2(NUM_BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  input  logic [31:0]          tlast_interval,
  output logic [IDX_W-1:0]     beat_index,
  output logic [31:0]          packets_sent
);

  localparam int               PKT_W    = NUM_BEATS * OUT_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  serializer_state_t    state_q, state_d;
  logic [IDX_W-1:0]     beat_idx_q, beat_idx_d, beat_idx_nxt;
  logic [PKT_W-1:0]     pkt_q, pkt_d;
  logic                 last_q, last_d;
  logic [OUT_WIDTH-1:0] tdata_q, tdata_d;
  logic                 tlast_q, tlast_d;
  logic [31:0]          pkts_q, pkts_d;
  logic                 final_hs;
  logic                 capture;
  logic                 tlast_now;

  always_comb begin
    final_hs      = (state_q == SEND) && (beat_idx_q == LAST_IDX) && M_AXIS_tready;
    // Accepting on the final-beat handshake lets packets stream without a bubble.
    S_AXIS_tready = (state_q == IDLE) || final_hs;
    capture       = S_AXIS_tvalid && S_AXIS_tready;
    beat_idx_nxt  = beat_idx_q + 1'b1;

    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    pkt_d      = pkt_q;
    last_d     = last_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    pkts_d     = final_hs ? pkts_q + 32'd1 : pkts_q;

    if (capture) begin
      state_d    = SEND;
      beat_idx_d = '0;
      pkt_d      = PKT_W'(S_AXIS_tdata);
      last_d     = S_AXIS_tlast;
      tdata_d    = S_AXIS_tdata[OUT_WIDTH-1:0];
      tlast_d    = 1'b0;
    end else if (final_hs) begin
      state_d    = IDLE;
      beat_idx_d = '0;
      tlast_d    = 1'b0;
    end else if ((state_q == SEND) && M_AXIS_tready) begin
      beat_idx_d = beat_idx_nxt;
      tdata_d    = pkt_q[int'(beat_idx_nxt) * OUT_WIDTH +: OUT_WIDTH];
      // Interval state only moves at capture/packet end, so it is settled here.
      tlast_d    = (beat_idx_nxt == LAST_IDX) && tlast_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_idx_q <= '0;
      last_q     <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      pkts_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      last_q     <= last_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      pkts_q     <= pkts_d;
    end
  end

  always_ff @(posedge clk) begin
    pkt_q <= pkt_d;
  end

  trace_tlast_generator u_tlast_gen (
    .clk            (clk),
    .rst            (rst),
    .packet_done    (final_hs),
    .captured_tlast (last_q),
    .capture        (capture),
    .tlast_interval (tlast_interval),
    .tlast_now      (tlast_now)
  );

  assign M_AXIS_tvalid = (state_q == SEND);
  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tlast  = tlast_q;
  assign beat_index    = beat_idx_q;
  assign packets_sent  = pkts_q;

endmodule

// File: tb/tb_trace_axis_serializer.sv
`timescale 1ns/1ps
module tb_trace_axis_serializer;

  localparam int IW = 160;
  localparam int OW = 64;
  localparam int NB = 3;

  logic          clk;
  logic          rst;
  logic          S_AXIS_tvalid;
  logic          S_AXIS_tready;
  logic [IW-1:0] S_AXIS_tdata;
  logic          S_AXIS_tlast;
  logic          M_AXIS_tvalid;
  logic          M_AXIS_tready;
  logic [OW-1:0] M_AXIS_tdata;
  logic          M_AXIS_tlast;
  logic [31:0]   tlast_interval;
  logic [1:0]    beat_index;
  logic [31:0]   packets_sent;

  trace_axis_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk            (clk),
    .rst            (rst),
    .S_AXIS_tvalid  (S_AXIS_tvalid),
    .S_AXIS_tready  (S_AXIS_tready),
    .S_AXIS_tdata   (S_AXIS_tdata),
    .S_AXIS_tlast   (S_AXIS_tlast),
    .M_AXIS_tvalid  (M_AXIS_tvalid),
    .M_AXIS_tready  (M_AXIS_tready),
    .M_AXIS_tdata   (M_AXIS_tdata),
    .M_AXIS_tlast   (M_AXIS_tlast),
    .tlast_interval (tlast_interval),
    .beat_index     (beat_index),
    .packets_sent   (packets_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready: always high, or random per cycle in backpressure mode.
  logic bp_mode;
  initial begin
    M_AXIS_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      M_AXIS_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          m_cnt    = 0;
  int          exp_idx  = 0;
  int          exp_pkts = 0;
  logic        fresh    = 1'b1;
  logic        st_v     = 1'b0;
  logic [63:0] st_data;
  logic        st_last;
  logic [1:0]  st_idx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model + scoreboard. A packet accepted at the coming edge turns
  // into NB expected beats; tlast follows the input flag or the packet count.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cnt    = 0;
      exp_idx  = 0;
      exp_pkts = 0;
      fresh    = 1'b1;
      st_v     = 1'b0;
    end else begin
      chk("m_tvalid", 64'(M_AXIS_tvalid), 64'(exp_q.size() != 0));
      chk("s_tready", 64'(S_AXIS_tready),
          (exp_q.size() == 0) ? 64'd1 : 64'((exp_idx == NB - 1) && M_AXIS_tready));
      chk("packets_sent", 64'(packets_sent), 64'(exp_pkts));
      if (fresh && !M_AXIS_tvalid) begin
        chk("reset_tdata", M_AXIS_tdata, 64'd0);
        chk("reset_tlast", 64'(M_AXIS_tlast), 64'd0);
        chk("reset_beat_index", 64'(beat_index), 64'd0);
      end
      if (M_AXIS_tvalid) begin
        if (st_v) begin
          chk("stall_tdata", M_AXIS_tdata, st_data);
          chk("stall_tlast", 64'(M_AXIS_tlast), 64'(st_last));
          chk("stall_beat_index", 64'(beat_index), 64'(st_idx));
        end
        chk("beat_index", 64'(beat_index), 64'(exp_idx));
        if (exp_q.size() != 0) begin
          chk("tdata", M_AXIS_tdata, exp_q[0].data);
          chk("tlast", 64'(M_AXIS_tlast), 64'(exp_q[0].last));
          if (M_AXIS_tready) begin
            void'(exp_q.pop_front());
            if (exp_idx == NB - 1) begin
              exp_idx = 0;
              exp_pkts++;
            end else begin
              exp_idx++;
            end
          end
        end
        st_v    = !M_AXIS_tready;
        st_data = M_AXIS_tdata;
        st_last = M_AXIS_tlast;
        st_idx  = beat_index;
      end else begin
        st_v = 1'b0;
      end
      if (S_AXIS_tvalid && S_AXIS_tready) begin
        logic [NB*OW-1:0] padded;
        logic             tl;
        beat_t            b;
        padded = {32'h0, S_AXIS_tdata};
        tl = S_AXIS_tlast || ((tlast_interval != 0) && (m_cnt == int'(tlast_interval) - 1));
        m_cnt = tl ? 0 : m_cnt + 1;
        for (int k = 0; k < NB; k++) begin
          b.data = padded[k*OW +: OW];
          b.last = (k == NB - 1) && tl;
          exp_q.push_back(b);
        end
        fresh = 1'b0;
      end
    end
  end

  function automatic logic [IW-1:0] rand_pkt();
    logic [IW-1:0] d;
    for (int i = 0; i < IW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    S_AXIS_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Leaves tvalid high so consecutive calls stream back-to-back.
  task automatic send_pkt(input logic [IW-1:0] d, input logic l);
    int n;
    S_AXIS_tdata  = d;
    S_AXIS_tlast  = l;
    S_AXIS_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        $display("FAIL accept_timeout: actual=stalled required=accept at %0t", $time);
        $fatal(1, "input never accepted");
      end
    end while (!S_AXIS_tready);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    S_AXIS_tvalid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    S_AXIS_tvalid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 || M_AXIS_tvalid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 2000) begin
        $display("FAIL drain_timeout: actual=busy required=idle at %0t", $time);
        $fatal(1, "output never drained");
      end
    end
    idle(2);
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    bp_mode        = 1'b0;
    S_AXIS_tvalid  = 1'b0;
    S_AXIS_tdata   = '0;
    S_AXIS_tlast   = 1'b0;
    tlast_interval = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Single directed packet, ready held high.
    send_pkt(160'h11111111_2222222222222222_3333333333333333, 1'b0);
    drain();

    // Four packets back-to-back.
    for (int i = 0; i < 4; i++) send_pkt(rand_pkt(), 1'b0);
    drain();

    // Random backpressure with random input gaps and flags.
    bp_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_pkt(rand_pkt(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    drain();
    bp_mode = 1'b0;

    // Interval-generated tlast, then interval disabled.
    do_reset();
    tlast_interval = 32'd3;
    for (int i = 0; i < 7; i++) send_pkt(rand_pkt(), 1'b0);
    drain();
    tlast_interval = 32'd0;
    for (int i = 0; i < 3; i++) send_pkt(rand_pkt(), 1'b0);
    drain();

    // Input tlast on packet 2 restarts the interval.
    do_reset();
    tlast_interval = 32'd3;
    for (int i = 1; i <= 6; i++) send_pkt(rand_pkt(), i == 2);
    drain();

    // Interval 1 under backpressure.
    tlast_interval = 32'd1;
    bp_mode = 1'b1;
    for (int i = 0; i < 4; i++) send_pkt(rand_pkt(), 1'b0);
    drain();
    bp_mode = 1'b0;

    // Reset while beat 1 of a packet is presented.
    tlast_interval = 32'd2;
    send_pkt(rand_pkt(), 1'b1);
    S_AXIS_tvalid = 1'b0;
    n = 0;
    while (beat_index != 2'd1) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        $display("FAIL beat1_timeout: actual=%0d required=1", beat_index);
        $fatal(1, "beat 1 never presented");
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    send_pkt(rand_pkt(), 1'b0);
    send_pkt(rand_pkt(), 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
